// File: rtl/chimp_round_controller.sv
// Round sequencer for the chimp-test board: clear, load, show, pick, evaluate, advance or strike.
// Every output is a register; strobes are decoded from the next state so they line up with it.
module chimp_round_controller #(
    parameter int          START_LEVEL  = 4,
    parameter int          MAX_LEVEL    = 25,
    parameter int          MAX_STRIKES  = 3,
    parameter logic [7:0]  LFSR_SEED    = 8'hA5,
    parameter int          CLICK_SETTLE = 2
) (
    input  logic       clk,
    input  logic       iReset,
    input  logic       iStart,
    input  logic       iMouseClick,
    input  logic       iDoneLoad,
    input  logic       iChoseCorrectNum,
    input  logic       iChoseWrongNum,
    output logic       oResetBoard,
    output logic       oLoadEnable,
    output logic       oShowEnable,
    output logic       oMouseClick,
    output logic [7:0] oRandNum,
    output logic [4:0] oLevel,
    output logic [4:0] oNumToChoose,
    output logic [2:0] oStrikes,
    output logic [4:0] oBestLevel,
    output logic       oGameOver
);

    localparam int CW = $clog2(CLICK_SETTLE + 1);

    typedef enum logic [3:0] {
        S_IDLE, S_CLEAR, S_LOAD, S_SHOW, S_PICK, S_ISSUE,
        S_SETTLE, S_EVAL, S_ADVANCE, S_STRIKE, S_GAME_OVER
    } state_t;

    state_t        state_q, state_d;
    logic          from_show_q, from_show_d;
    logic          first_load_q, first_load_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [4:0]    level_q, level_d;
    logic [4:0]    num_q, num_d;
    logic [2:0]    strikes_q, strikes_d;
    logic [4:0]    best_q, best_d;
    logic [7:0]    lfsr_q, lfsr_d;
    logic          reset_board_q, reset_board_d;
    logic          load_en_q, load_en_d;
    logic          show_en_q, show_en_d;
    logic          click_q, click_d;
    logic          game_over_q, game_over_d;

    // State and output registers
    always_ff @(posedge clk) begin
        if (iReset) begin
            state_q       <= S_IDLE;
            from_show_q   <= 1'b0;
            first_load_q  <= 1'b0;
            cnt_q         <= '0;
            level_q       <= 5'(START_LEVEL);
            num_q         <= 5'd1;
            strikes_q     <= 3'd0;
            best_q        <= 5'd0;
            lfsr_q        <= LFSR_SEED;
            reset_board_q <= 1'b0;
            load_en_q     <= 1'b0;
            show_en_q     <= 1'b0;
            click_q       <= 1'b0;
            game_over_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            from_show_q   <= from_show_d;
            first_load_q  <= first_load_d;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            num_q         <= num_d;
            strikes_q     <= strikes_d;
            best_q        <= best_d;
            lfsr_q        <= lfsr_d;
            reset_board_q <= reset_board_d;
            load_en_q     <= load_en_d;
            show_en_q     <= show_en_d;
            click_q       <= click_d;
            game_over_q   <= game_over_d;
        end
    end

    // Next-state and counter updates
    always_comb begin
        state_d      = state_q;
        from_show_d  = from_show_q;
        cnt_d        = cnt_q;
        level_d      = level_q;
        num_d        = num_q;
        strikes_d    = strikes_q;
        best_d       = best_q;
        lfsr_d       = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        // The done flag seen in the first LOAD cycle is left over from the previous round.
        first_load_d = (state_q == S_CLEAR);

        case (state_q)
            S_IDLE, S_GAME_OVER: begin
                if (iStart) begin
                    state_d   = S_CLEAR;
                    level_d   = 5'(START_LEVEL);
                    strikes_d = 3'd0;
                end
            end
            S_CLEAR: begin
                num_d   = 5'd1;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                if (iDoneLoad && !first_load_q) state_d = S_SHOW;
            end
            S_SHOW: begin
                if (iMouseClick) begin
                    state_d     = S_ISSUE;
                    from_show_d = 1'b1;
                end
            end
            S_PICK: begin
                if (iMouseClick) begin
                    state_d     = S_ISSUE;
                    from_show_d = 1'b0;
                end
            end
            S_ISSUE: begin
                cnt_d   = CW'(CLICK_SETTLE);
                state_d = S_SETTLE;
            end
            S_SETTLE: begin
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) state_d = S_EVAL;
            end
            S_EVAL: begin
                if (iChoseWrongNum) begin
                    state_d = S_STRIKE;
                end else if (iChoseCorrectNum) begin
                    if (num_q == level_q) begin
                        state_d = S_ADVANCE;
                    end else begin
                        num_d   = num_q + 5'd1;
                        state_d = S_PICK;
                    end
                end else begin
                    state_d = from_show_q ? S_SHOW : S_PICK;
                end
            end
            S_ADVANCE: begin
                if (level_q > best_q) best_d = level_q;
                if (level_q == 5'(MAX_LEVEL)) begin
                    state_d = S_GAME_OVER;
                end else begin
                    level_d = level_q + 5'd1;
                    state_d = S_CLEAR;
                end
            end
            S_STRIKE: begin
                strikes_d = strikes_q + 3'd1;
                state_d   = (strikes_q + 3'd1 == 3'(MAX_STRIKES)) ? S_GAME_OVER : S_CLEAR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Output decode from the upcoming state
    always_comb begin
        reset_board_d = (state_d == S_CLEAR);
        load_en_d     = (state_d == S_LOAD);
        click_d       = (state_d == S_ISSUE);
        game_over_d   = (state_d == S_GAME_OVER);
        // Numbers stay visible while a click made from SHOW is being evaluated.
        show_en_d     = (state_d == S_SHOW) ||
                        (from_show_d && (state_d == S_ISSUE || state_d == S_SETTLE ||
                                         state_d == S_EVAL));
    end

    assign oResetBoard  = reset_board_q;
    assign oLoadEnable  = load_en_q;
    assign oShowEnable  = show_en_q;
    assign oMouseClick  = click_q;
    assign oRandNum     = lfsr_q;
    assign oLevel       = level_q;
    assign oNumToChoose = num_q;
    assign oStrikes     = strikes_q;
    assign oBestLevel   = best_q;
    assign oGameOver    = game_over_q;

endmodule
